demux14_stream: RTL
===================

# demux14_stream

Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the team's 4-to-1 selector. Accepts one data word per handshake on a single input channel and steers it, by the 2-bit selector {s1,s0}, into one of four single-entry output registers, each with its own valid/ready handshake. It sits between a single producer and four independent consumers, providing back-pressure per channel so that a stalled consumer blocks only traffic addressed to it.

## Interface
- WIDTH, 8, data word width in bits (1..32)
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- s0  input  1  selector LSB
- s1  input  1  selector MSB; {s1,s0} = channel index 0..3
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  block can accept the word for the currently selected channel
- in_data  input  WIDTH  input word
- out_valid  output  4  bit i: channel i register holds a word
- out_ready  input  4  bit i: consumer i takes the word this cycle
- w0, w1, w2, w3  output  WIDTH each  channel 0..3 output registers
- cnt0, cnt1, cnt2, cnt3  output  8 each  delivered-word counters (present only with DEMUX14_COUNT_EN)

## Operation
- Per channel i: two-state FSM, EMPTY (out_valid[i]=0) / FULL (out_valid[i]=1).
- sel = {s1,s0}, sampled combinationally; only meaningful in a cycle where in_valid=1.
- in_ready = ~out_valid[sel] | out_ready[sel] (combinational; allows drain-and-refill in the same cycle).
- Accept: in_valid & in_ready. On accept, w[sel] <= in_data and channel sel goes/stays FULL.
- Drain of channel i: out_valid[i] & out_ready[i]. Channel i goes EMPTY unless it is also the accept target that cycle, in which case it stays FULL with the new word.
- Channels not selected are unaffected by the input side; each drains independently of all others, several in the same cycle if their ready bits are high.
- Stall: in_valid=1 with in_ready=0 -> no state change; producer must hold in_data and sel stable until accepted.
- out_ready[i] while channel i EMPTY: ignored.
- w[i] holds its value when EMPTY (not cleared on drain); w[i] is stable while out_valid[i]=1 and not drained.
- Word order per channel is preserved; no ordering is defined across channels.

## Timing
- Reset (asynchronous assert, released synchronously by system): out_valid=4'b0000, w0..w3=0, cnt0..cnt3=0; in_ready then equals 1 for any sel.
- Latency: word accepted at edge N is on w[sel] with out_valid[sel]=1 after edge N; earliest drain at edge N+1.
- Throughput: one word per cycle sustained on one channel when its out_ready stays 1, or rotating across channels.
- Reset mid-operation: all held words discarded, no partial state survives; first accept possible on the first edge after rst deasserts.
- in_ready has a combinational path from in_valid-independent inputs s1, s0, out_ready; no path from in_valid to in_ready.

## Configuration
- DEMUX14_COUNT_EN defined: ports cnt0..cnt3 exist; cnt[i] increments by 1 on every drain of channel i, 8-bit, wraps 255 -> 0, reset to 0.
- DEMUX14_COUNT_EN undefined: cnt0..cnt3 ports and counter logic absent; all other behaviour identical.

## Test plan
- Reset: assert rst mid-stream with out_valid=4'b1011 -> out_valid=0, w0..w3=0, cnt all 0 immediately, in_ready=1.
- Route all: out_ready=4'b1111, send 8'hA0,8'hA1,8'hA2,8'hA3 with sel=0,1,2,3 on consecutive cycles -> each w[i]=8'hA<i> with out_valid[i] pulsed one cycle, one cycle after its accept.
- Back-pressure: out_ready[2]=0, send 8'h55 then 8'h66 to sel=2 -> 8'h55 held on w2, in_ready=0 for second word; sel=1 word 8'h77 still accepted and delivered on w1; raise out_ready[2] -> 8'h66 accepted same cycle 8'h55 drains, appears next cycle.
- Stream: out_ready[3]=1, sel=3, in_valid=1 for 10 cycles with data 0..9 -> in_ready stays 1, w3 shows 0..9 in order, out_valid[3] high 10 consecutive cycles.
- Idle ready: out_ready=4'b1111 with no input for 5 cycles -> out_valid stays 0, w0..w3 unchanged, counters unchanged.
- DEMUX14_COUNT_EN: 257 words drained on channel 0 -> cnt0=1, cnt1..cnt3=0.

Source files
------------

// File: rtl/demux14_stream.sv
// demux14_stream: registered 1-to-4 stream demultiplexer.
// One input channel is steered by {s1,s0} into one of four single-entry
// output registers, each with its own valid/ready handshake.
// Optional feature macro: DEMUX14_COUNT_EN adds per-channel 8-bit
// delivered-word counters on ports cnt0..cnt3.
//
// Handshake rules (all channels): a transfer happens on a rising edge where
// valid and ready are both high. valid, once raised, holds with its data
// stable until the transfer. ready may depend combinationally on the
// selector and on out_ready, but never on in_valid.
module demux14_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0,
    input  logic             s1,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] w0,
    output logic [WIDTH-1:0] w1,
    output logic [WIDTH-1:0] w2,
    output logic [WIDTH-1:0] w3
`ifdef DEMUX14_COUNT_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2,
    output logic [7:0]       cnt3
`endif
);

    // Per-channel two-state FSM encoding; the state bit is exported
    // directly as out_valid, so out_valid doubles as the debug view.
    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic [1:0]       sel;
    logic             accept;
    logic [3:0]       drain;
    logic [3:0]       state_q;
    logic [3:0]       state_d;
    logic [WIDTH-1:0] word_q [4];
    logic [WIDTH-1:0] word_d [4];

    assign sel = {s1, s0};

    // Selected channel can take a word if empty or draining this cycle.
    always_comb begin
        in_ready = (state_q[sel] == EMPTY) | out_ready[sel];
    end

    // Transfer strobes for the input side and for each output channel.
    always_comb begin
        accept = in_valid & in_ready;
        for (int i = 0; i < 4; i++) begin
            drain[i] = (state_q[i] == FULL) & out_ready[i];
        end
    end

    // Next state: drain empties a channel, accept refills the target;
    // accept wins so drain-and-refill leaves the channel FULL.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            word_d[i]  = word_q[i];
            if (drain[i]) begin
                state_d[i] = EMPTY;
            end
            if (accept && (sel == 2'(i))) begin
                state_d[i] = FULL;
                word_d[i]  = in_data;
            end
        end
    end

    // State and data registers; reset discards every held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= {4{EMPTY}};
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= word_d[i];
            end
        end
    end

    assign out_valid = state_q;
    assign w0        = word_q[0];
    assign w1        = word_q[1];
    assign w2        = word_q[2];
    assign w3        = word_q[3];

`ifdef DEMUX14_COUNT_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    // Delivered-word counters: +1 per drain, natural 8-bit wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (drain[i]) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule
